// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Write-back store buffer between a core and a word-addressed RAM.
//            Stores are queued in a DEPTH-entry FIFO and written to RAM in
//            order during cycles in which the core is idle. A store to an
//            address that is already queued overwrites the queued data in
//            place. Loads that hit a queued entry are forwarded from the
//            buffer. Loads that miss are passed through to the RAM.
// Ports    : CLK            - clock, rising edge
//            RSTn           - asynchronous active-low reset
//            MemWrite       - core store request
//            MemRead        - core load request
//            address        - core word address (10 b)
//            write_data     - core store data (32 b)
//            read_data      - load data returned to the core (32 b)
//            stall          - store not accepted this cycle
//            empty          - buffer holds no valid entries
//            ram_MemWrite   - RAM write strobe
//            ram_MemRead    - RAM read strobe
//            ram_address    - RAM word address (10 b)
//            ram_write_data - RAM write data (32 b)
//            ram_read_data  - RAM combinational read data (32 b)
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [9:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        empty,
  output logic        ram_MemWrite,
  output logic        ram_MemRead,
  output logic [9:0]  ram_address,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Entry storage. No reset: validity is derived from head and count alone.
  logic [9:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_valid;
  logic             w_match;
  logic [PTR_W-1:0] w_match_idx;
  logic             w_full;
  logic             w_accept;
  logic             w_append;
  logic             w_load;
  logic             w_drain;

  // Entry i is valid when its distance from head is below count. DEPTH is
  // a power of two, so the PTR_W-bit subtraction wraps naturally. Because
  // matching stores coalesce, at most one entry can match.
  always_comb begin
    w_valid     = '0;
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_head)} < r_count);
      if (w_valid[i] && (r_addr[i] == address)) begin
        w_match     = 1'b1;
        w_match_idx = PTR_W'(i);
      end
    end
  end

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign stall    = MemWrite & w_full & ~w_match;
  assign w_accept = MemWrite & ~stall;
  assign w_append = w_accept & ~w_match;
  // A load issued together with a store is ignored.
  assign w_load   = MemRead & ~MemWrite;
  // Drain in idle cycles, and also in stall cycles so the held store finds
  // a free slot on the following edge.
  assign w_drain  = (r_count != '0) & ((~MemWrite & ~MemRead) | stall);
  assign empty    = (r_count == '0);

  // Pointer and count state. Store and drain never coincide: a drain in a
  // store cycle only happens when that store is stalled.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_append) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_append, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      if (w_match) begin
        r_data[w_match_idx] <= write_data;
      end else begin
        r_addr[r_tail] <= address;
        r_data[r_tail] <= write_data;
      end
    end
  end

  // RAM-side strobes and core read data. Every output is forced to zero
  // while reset is asserted, regardless of the core inputs.
  always_comb begin
    ram_MemWrite   = RSTn & w_drain;
    ram_MemRead    = RSTn & w_load & ~w_match;
    ram_address    = '0;
    ram_write_data = '0;
    read_data      = '0;
    if (ram_MemWrite) begin
      ram_address    = r_addr[r_head];
      ram_write_data = r_data[r_head];
    end else if (ram_MemRead) begin
      ram_address = address;
    end
    if (RSTn && w_load) begin
      read_data = w_match ? r_data[w_match_idx] : ram_read_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 DEPTH, 4, number of buffered stores (power of two, 2..16).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 MemWrite  input  1  core store request.
REQ-005 MemRead  input  1  core load request.
REQ-006 address  input  10  core word address.
REQ-007 write_data  input  32  core store data.
REQ-008 read_data  output  32  load data returned to core.
REQ-009 stall  output  1  store not accepted this cycle; core holds request stable.
REQ-010 empty  output  1  no valid entries.
REQ-011 ram_MemWrite  output  1  RAM write strobe.
REQ-012 ram_MemRead  output  1  RAM read strobe.
REQ-013 ram_address  output  10  RAM word address.
REQ-014 ram_write_data  output  32  RAM write data.
REQ-015 ram_read_data  input  32  RAM read data; RAM read is combinational, write is on rising CLK.

Function
REQ-016 Block SHALL hold a FIFO of DEPTH entries {address, data} with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-017 match SHALL be asserted when address equals the address of any valid entry; at most one entry can match.
REQ-018 stall SHALL equal MemWrite & (count==DEPTH) & !match, combinational in the same cycle.
REQ-019 Accepted store (MemWrite=1, stall=0) with match SHALL overwrite that entry's data at the edge, count and order unchanged, allowed when full.
REQ-020 Accepted store without match SHALL append at tail at the edge, count+1.
REQ-021 Load with match SHALL return matching entry data on read_data combinationally, ram_MemRead=0.
REQ-022 Load without match SHALL drive ram_MemRead=1, ram_address=address, read_data=ram_read_data.
REQ-023 Drain SHALL occur when count>0 and (MemWrite=0 & MemRead=0, or stall=1): ram_MemWrite=1, ram_address/ram_write_data = head entry; head removed at the edge.
REQ-024 Drain in a stall cycle SHALL free the slot so the held store is accepted the following cycle (one stall cycle per full event).
REQ-025 ram_MemWrite SHALL be 0 in any cycle with an accepted store or a load; entries drain strictly in FIFO order.
REQ-026 MemRead=1 & MemWrite=1 is illegal: store SHALL be processed, load ignored, ram_MemRead=0.
REQ-027 read_data SHALL be 0 when MemRead=0; ram_address and ram_write_data SHALL be 0 when neither RAM strobe is active.
REQ-028 empty SHALL equal (count==0).

Reset
REQ-029 RSTn=0 SHALL immediately clear count and pointers, discarding pending stores without writing them to RAM.
REQ-030 While RSTn=0: stall=0, empty=1, ram_MemWrite=0, ram_MemRead=0, read_data=0, ram_address=0, ram_write_data=0.
REQ-031 Reset release SHALL need no further initialization; first store is accepted on the first edge after RSTn rises.

Verification
REQ-032 Store 0x11 to addr 5, then idle -> empty=0 after edge; idle cycle ram_MemWrite=1, ram_address=5, ram_write_data=0x11; empty=1 after.
REQ-033 Store 0xAA to addr 7, next cycle load addr 7 -> read_data=0xAA, ram_MemRead=0, ram_MemWrite=0.
REQ-034 Back-to-back stores to addr 1..5, data 0x10..0x50, DEPTH=4 -> 5th store stall=1 for one cycle with RAM write addr 1/0x10; accepted next cycle; idle then drains addr 2,3,4,5 in order.
REQ-035 Store addr 3 data 0x1 then addr 3 data 0x2, also with buffer full -> no stall, count unchanged; drain writes addr 3 data 0x2 exactly once.
REQ-036 Buffer holding addr 4, load addr 9 -> ram_MemRead=1, ram_address=9, read_data=ram_read_data, no RAM write that cycle.
REQ-037 Three stores pending, RSTn pulsed low mid-cycle -> empty=1 asynchronously; no ram_MemWrite afterwards; RAM contents unchanged.
